// File: rtl/or16_accum.sv
// OR16_ACCUM: OR-accumulates 16-bit words over a frame and presents the OR, a zero flag and a saturating word count.
// Latency: the result is valid one cycle after the edge that accepts the last word or registers a flush.
// Backpressure: in_ready drops while a result is pending, and the result holds until out_ready is seen.
module or16_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   input  logic        flush,
   output logic [15:0] out_data,
   output logic        out_zero,
   output logic [7:0]  out_count,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_acc;
   logic [7:0]  r_count;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [15:0] r_out_data;
   logic        r_out_zero;
   logic [7:0]  r_out_count;

   logic        w_accept;
   logic [15:0] w_acc_upd;
   logic [7:0]  w_cnt_upd;

   // Values the accumulator and counter take at this edge; IDLE starts a new frame.
   always_comb begin
      w_accept  = in_valid & r_in_ready;
      w_acc_upd = r_acc;
      w_cnt_upd = r_count;
      if (w_accept) begin
         if (r_state == ST_IDLE) begin
            w_acc_upd = in_data;
            w_cnt_upd = 8'd1;
         end else begin
            w_acc_upd = r_acc | in_data;
            w_cnt_upd = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
         end
      end
   end

   // Frame FSM with registered handshake and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_acc       <= 16'h0000;
         r_count     <= 8'd0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= 16'h0000;
         r_out_zero  <= 1'b0;
         r_out_count <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE, ST_ACC: begin
               r_acc   <= w_acc_upd;
               r_count <= w_cnt_upd;
               // flush only closes a frame that already holds at least one word
               if ((w_accept && in_last) || (r_state == ST_ACC && flush)) begin
                  r_state     <= ST_DONE;
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_acc_upd;
                  r_out_zero  <= (w_acc_upd == 16'h0000);
                  r_out_count <= w_cnt_upd;
               end else if (w_accept) begin
                  r_state <= ST_ACC;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_out_data  <= 16'h0000;
                  r_out_zero  <= 1'b0;
                  r_out_count <= 8'd0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_out_data  <= 16'h0000;
               r_out_zero  <= 1'b0;
               r_out_count <= 8'd0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_zero  = r_out_zero;
   assign out_count = r_out_count;

endmodule

// File: tb/tb_or16_accum.sv
// Directed bench for or16_accum: inputs change on the falling edge, outputs are checked on the falling edge.
// Latency: each step advances exactly one rising edge before checking.
// Backpressure: out_ready is driven explicitly to hold or release results.
module tb_or16_accum;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        flush;
   logic [15:0] out_data;
   logic        out_zero;
   logic [7:0]  out_count;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   or16_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_zero  (out_zero),
      .out_count (out_count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one rising edge, then settle on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic f);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      flush    = f;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [15:0] d,
                          input logic [7:0] c, input logic z, input logic r);
      chk({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, v});
      chk({tag, ".out_data"},  out_data, d);
      chk({tag, ".out_count"}, {8'd0, out_count}, {8'd0, c});
      chk({tag, ".out_zero"},  {15'd0, out_zero}, {15'd0, z});
      chk({tag, ".in_ready"},  {15'd0, in_ready}, {15'd0, r});
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      chk_out("reset", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      // flush in IDLE is ignored
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      step();
      chk_out("idle_flush", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // three-word frame, consumer always ready
      out_ready = 1'b1;
      drive(1'b1, 16'h0001, 1'b0, 1'b0);
      step();
      chk_out("f1_w1", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);
      drive(1'b1, 16'h0010, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h8000, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_out("f1_done", 1'b1, 16'h8011, 8'd3, 1'b0, 1'b0);
      step();
      chk_out("f1_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // single zero word; valid input during DONE must not be accepted
      out_ready = 1'b0;
      drive(1'b1, 16'h0000, 1'b1, 1'b0);
      step();
      drive(1'b1, 16'hFFFF, 1'b1, 1'b0);
      chk_out("f2_done", 1'b1, 16'h0000, 8'd1, 1'b1, 1'b0);
      step();
      chk_out("f2_hold", 1'b1, 16'h0000, 8'd1, 1'b1, 1'b0);
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      out_ready = 1'b1;
      step();
      chk_out("f2_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // flush without a word, result held under backpressure
      out_ready = 1'b0;
      drive(1'b1, 16'h00F0, 1'b0, 1'b0);
      step();
      chk_out("f3_acc", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);
      drive(1'b0, 16'h0000, 1'b0, 1'b1);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("f3_hold%0d", i), 1'b1, 16'h00F0, 8'd1, 1'b0, 1'b0);
         step();
      end
      out_ready = 1'b1;
      step();
      chk_out("f3_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // flush concurrent with an accepted word
      drive(1'b1, 16'h00F0, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0F00, 1'b0, 1'b1);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_out("f4_done", 1'b1, 16'h0FF0, 8'd2, 1'b0, 1'b0);
      step();
      chk_out("f4_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // 300-word frame saturates the counter
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 16'h0001 << (i % 16), (i == 299), 1'b0);
         step();
      end
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_out("f5_done", 1'b1, 16'hFFFF, 8'd255, 1'b0, 1'b0);
      step();
      chk_out("f5_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      // asynchronous reset mid-frame discards the partial frame
      drive(1'b1, 16'h0100, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0200, 1'b0, 1'b0);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk_out("f6_rst", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 16'h0003, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      chk_out("f6_done", 1'b1, 16'h0003, 8'd1, 1'b0, 1'b0);
      step();
      chk_out("f6_idle", 1'b0, 16'h0000, 8'd0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/or16_accum.md
OR16_ACCUM -- requirements
Module: or16_accum

Interface
REQ-001 The module SHALL have no parameters; all data paths are fixed at 16 bits and the word counter at 8 bits.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_data  input  16  word to be OR-accumulated.
REQ-005 in_valid  input  1  in_data is valid this cycle.
REQ-006 in_last  input  1  the word is the final word of its frame; qualified by in_valid.
REQ-007 in_ready  output  1  the block accepts a word this cycle.
REQ-008 flush  input  1  closes the current frame early; sampled only in state ACC.
REQ-009 out_data  output  16  bitwise OR of all words in the completed frame.
REQ-010 out_zero  output  1  high when out_data == 16'h0000 while out_valid is high.
REQ-011 out_count  output  8  number of words accepted in the frame, saturating.
REQ-012 out_valid  output  1  the result is presented.
REQ-013 out_ready  input  1  the consumer takes the result this cycle.

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready; no other input word affects state.
REQ-015 The block SHALL implement a three-state FSM with states IDLE, ACC and DONE.
REQ-016 In IDLE, in_ready=1 and out_valid=0; on accept: acc<=in_data, count<=1, next state DONE if in_last, else ACC.
REQ-017 In ACC, in_ready=1 and out_valid=0; on accept: acc<=acc|in_data, count<=count+1 (saturating at 255), next state DONE if in_last, else ACC.
REQ-018 In ACC, flush=1 without an accepted word SHALL move the FSM to DONE with acc and count unchanged.
REQ-019 In ACC, flush=1 together with an accepted word SHALL include that word (acc and count updated) and move the FSM to DONE, regardless of in_last.
REQ-020 flush SHALL be ignored in IDLE and DONE; an empty frame is never produced.
REQ-021 In DONE, in_ready=0 and out_valid=1; out_data=acc, out_count=count, out_zero=(acc==0).
REQ-022 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; a new word is accepted no earlier than the following cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_zero and out_count SHALL hold constant.
REQ-024 out_valid SHALL rise exactly one cycle after the edge that accepted the last word (or registered the flush).
REQ-025 When out_valid=0, out_data, out_zero and out_count SHALL be driven to 0.
REQ-026 in_ready SHALL be a function of FSM state only, with no combinational path from out_ready, in_valid or flush.
REQ-027 Once count reaches 255, further accepted words SHALL still be OR-ed into acc, and count SHALL remain 255.
REQ-028 Frame throughput SHALL be one frame per N+1 cycles at minimum, where N is the number of words in the frame.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, acc=0, count=0, out_valid=0, out_data=0, out_zero=0, out_count=0 and in_ready=1, independent of clk.
REQ-030 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result; no result is emitted for that frame.
REQ-031 After rst deasserts, the first rising edge with in_valid=1 SHALL be treated as the start of a new frame.

Verification
REQ-032 Frame 0x0001, 0x0010, 0x8000 (last on the third word), out_ready=1 -> one cycle later out_valid=1, out_data=0x8011, out_count=3, out_zero=0; IDLE on the next cycle.
REQ-033 Single word 0x0000 with in_last=1 -> out_data=0x0000, out_zero=1, out_count=1; in_ready=0 while DONE.
REQ-034 Frame 0x00F0, then flush with no valid word, out_ready held 0 for 5 cycles -> out_data=0x00F0 and out_count=1 stable for all 5 cycles, then released on the out_ready pulse.
REQ-035 Flush concurrent with accepted word 0x0F00 after 0x00F0 (in_last=0) -> out_data=0x0FF0, out_count=2.
REQ-036 300-word frame of 1<<(i%16) -> out_data=0xFFFF, out_count=255 (saturated), out_zero=0.
REQ-037 rst pulsed asynchronously after two words of a frame -> outputs zero immediately; a following single-word frame 0x0003 -> out_data=0x0003, out_count=1, with no residue from the aborted frame.
